tt_dco: RTL and testbench

TT_DCO -- requirements
Module: tt_dco

---
 rtl/tt_dco.sv | 90 +++++++++
 tb/tb_tt_dco.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_dco.sv
// Digital phase-accumulator DCO: saturated FCW register, modulo accumulator, DCO-edge divider, scan path.
// Latency: i_ctrl to o_fcw 1 cycle; o_dco_clk is the accumulator MSB directly. No backpressure.
module tt_dco #(
   parameter int          ACC_W      = 24,
   parameter int unsigned FCW_BASE   = 24'h100000,
   parameter int          KDCO_SHIFT = 4,
   parameter int          DIV_N      = 8
) (
   input  logic             i_clk_gen,
   input  logic             i_rst,
   input  logic [15:0]      i_ctrl,
   input  logic             i_enable,
   input  logic             i_scan_en,
   input  logic             i_scan_in,
   output logic             o_dco_clk,
   output logic [ACC_W-1:0] o_fcw,
   output logic             o_fb_pulse,
   output logic             o_scan_out
);

   localparam int                CNT_W      = $clog2(DIV_N);
   localparam logic [31:0]       FCW_BASE_V = 32'(FCW_BASE);
   localparam logic signed [31:0] FCW_MAX   = (32'sd1 <<< (ACC_W-1)) - 32'sd1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV_N-1);

   logic signed [31:0] w_ctrl_ext;
   logic signed [31:0] w_sum;
   logic [ACC_W-1:0]   w_fcw_sat;
   logic               w_rise;
   logic               w_last;

   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_fcw;
   logic [CNT_W-1:0]   r_div_cnt;
   logic               r_msb_prev;
   logic               r_fb_pulse;

   assign w_ctrl_ext = {{16{i_ctrl[15]}}, i_ctrl};
   assign w_sum      = $signed(FCW_BASE_V) + (w_ctrl_ext <<< KDCO_SHIFT);

   // Clamp to [1, 2^(ACC_W-1)-1] so the DCO never stalls and never exceeds Nyquist.
   always_comb begin
      w_fcw_sat = w_sum[ACC_W-1:0];
      if (w_sum < 32'sd1) begin
         w_fcw_sat = ACC_W'(1);
      end else if (w_sum > FCW_MAX) begin
         w_fcw_sat = FCW_MAX[ACC_W-1:0];
      end
   end

   assign w_rise = r_acc[ACC_W-1] & ~r_msb_prev;
   assign w_last = (r_div_cnt == CNT_LAST);

   always_ff @(posedge i_clk_gen or posedge i_rst) begin
      if (i_rst) begin
         r_fcw <= FCW_BASE_V[ACC_W-1:0];
      end else begin
         r_fcw <= w_fcw_sat;
      end
   end

   always_ff @(posedge i_clk_gen or posedge i_rst) begin
      if (i_rst) begin
         r_acc      <= '0;
         r_div_cnt  <= '0;
         r_msb_prev <= 1'b0;
         r_fb_pulse <= 1'b0;
      end else if (i_scan_en) begin
         // Tracking the MSB while shifting keeps scan exit from looking like a DCO edge.
         r_acc      <= {r_acc[ACC_W-2:0], i_scan_in};
         r_msb_prev <= r_acc[ACC_W-1];
         r_fb_pulse <= 1'b0;
      end else if (i_enable) begin
         r_acc      <= r_acc + r_fcw;
         r_msb_prev <= r_acc[ACC_W-1];
         r_fb_pulse <= w_rise & w_last;
         if (w_rise) begin
            r_div_cnt <= w_last ? '0 : r_div_cnt + CNT_W'(1);
         end
      end else begin
         r_fb_pulse <= 1'b0;
      end
   end

   assign o_dco_clk  = r_acc[ACC_W-1];
   assign o_scan_out = r_acc[ACC_W-1];
   assign o_fcw      = r_fcw;
   assign o_fb_pulse = r_fb_pulse;

endmodule

// File: tb/tb_tt_dco.sv
// Bench for tt_dco: edge-counting model checked every cycle on the default instance, plus directed literals.
module tb_tt_dco;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ctrl;
   logic        en;
   logic        scan_en;
   logic        scan_in;

   logic        a_dco, a_pulse, a_scan;
   logic [23:0] a_fcw;
   logic        b_dco, b_pulse, b_scan;
   logic [23:0] b_fcw;
   logic        c_dco, c_pulse, c_scan;
   logic [23:0] c_fcw;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tt_dco dut_a (
      .i_clk_gen(clk), .i_rst(rst), .i_ctrl(ctrl), .i_enable(en),
      .i_scan_en(scan_en), .i_scan_in(scan_in),
      .o_dco_clk(a_dco), .o_fcw(a_fcw), .o_fb_pulse(a_pulse), .o_scan_out(a_scan)
   );

   tt_dco #(.KDCO_SHIFT(8)) dut_b (
      .i_clk_gen(clk), .i_rst(rst), .i_ctrl(ctrl), .i_enable(en),
      .i_scan_en(scan_en), .i_scan_in(scan_in),
      .o_dco_clk(b_dco), .o_fcw(b_fcw), .o_fb_pulse(b_pulse), .o_scan_out(b_scan)
   );

   tt_dco #(.FCW_BASE(24'h000020)) dut_c (
      .i_clk_gen(clk), .i_rst(rst), .i_ctrl(ctrl), .i_enable(en),
      .i_scan_en(scan_en), .i_scan_in(scan_in),
      .o_dco_clk(c_dco), .o_fcw(c_fcw), .o_fb_pulse(c_pulse), .o_scan_out(c_scan)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] model_fcw(input int base, input int kshift, input logic [15:0] c);
      int s;
      s = base + int'($signed(c)) * (1 << kshift);
      if (s < 1) return 24'd1;
      if (s > 8388607) return 24'h7FFFFF;
      return s[23:0];
   endfunction

   // Model of the default instance: rising DCO edges are counted in total, and
   // every DIV_N-th one yields a feedback pulse in the following cycle.
   logic [23:0] m_acc;
   logic [23:0] m_fcw;
   logic        m_prev;
   logic        m_pulse;
   int          m_edges;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_acc   <= 24'd0;
         m_fcw   <= 24'h100000;
         m_prev  <= 1'b0;
         m_pulse <= 1'b0;
         m_edges <= 0;
      end else begin
         m_fcw <= model_fcw(24'h100000, 4, ctrl);
         if (scan_en) begin
            m_acc   <= 24'((m_acc * 2) + scan_in);
            m_prev  <= (m_acc >= 24'h800000);
            m_pulse <= 1'b0;
         end else if (en) begin
            m_acc   <= 24'(m_acc + m_fcw);
            m_prev  <= (m_acc >= 24'h800000);
            if ((m_acc >= 24'h800000) && !m_prev) begin
               m_edges <= m_edges + 1;
               m_pulse <= ((m_edges + 1) % 8 == 0);
            end else begin
               m_pulse <= 1'b0;
            end
         end else begin
            m_pulse <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("a_fcw",   a_fcw,   m_fcw);
      chk("a_dco",   a_dco,   m_acc >= 24'h800000);
      chk("a_scan",  a_scan,  m_acc >= 24'h800000);
      chk("a_pulse", a_pulse, m_pulse);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          npulse;
      int          first_p;
      int          second_p;
      logic [23:0] pat;

      rst = 1'b1; ctrl = 16'h0000; en = 1'b1; scan_en = 1'b0; scan_in = 1'b0;
      npulse = 0; first_p = 0; second_p = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_fcw",   a_fcw,   24'h100000);
      chk("rst_a_dco",   a_dco,   1'b0);
      chk("rst_a_pulse", a_pulse, 1'b0);
      chk("rst_b_fcw",   b_fcw,   24'h100000);
      chk("rst_c_fcw",   c_fcw,   24'h000020);
      #2 rst = 1'b0;

      // Free-running defaults: 16-cycle DCO period, pulse every 128 cycles.
      for (int n = 1; n <= 260; n++) begin
         tick();
         if (n == 7)  chk("dco_n7",  a_dco, 1'b0);
         if (n == 8)  chk("dco_n8",  a_dco, 1'b1);
         if (n == 16) chk("dco_n16", a_dco, 1'b0);
         if (n == 24) chk("dco_n24", a_dco, 1'b1);
         if (a_pulse) begin
            npulse++;
            if (npulse == 1) first_p = n;
            else if (npulse == 2) second_p = n;
         end
      end
      chk("pulse_first",  first_p,  121);
      chk("pulse_second", second_p, 249);
      chk("pulse_count",  npulse,   2);

      ctrl = 16'h7FFF;
      #1 chk("fcw_latency", a_fcw, 24'h100000);
      tick();
      chk("fcw_pos_a", a_fcw, 24'h17FFF0);
      chk("fcw_pos_b", b_fcw, 24'h7FFFFF);
      ctrl = 16'h8000;
      tick();
      chk("fcw_neg_a", a_fcw, 24'h080000);
      chk("fcw_neg_b", b_fcw, 24'h000001);
      chk("fcw_neg_c", c_fcw, 24'h000001);
      ctrl = 16'h0000;
      tick();

      en = 1'b0;
      repeat (20) begin
         tick();
         chk("hold_pulse", a_pulse, 1'b0);
      end

      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_fcw",   a_fcw,   24'h100000);
      chk("midrst_dco",   a_dco,   1'b0);
      chk("midrst_pulse", a_pulse, 1'b0);
      chk("midrst_c_fcw", c_fcw,   24'h000020);
      #1 rst = 1'b0;
      tick();

      en = 1'b1;
      scan_en = 1'b1;
      pat = 24'hA5A5A5;
      for (int i = 0; i < 24; i++) begin
         scan_in = pat[23-i];
         tick();
         chk("scan_in_pulse", a_pulse, 1'b0);
      end
      for (int i = 0; i < 24; i++) begin
         scan_in = 1'b0;
         chk("scan_out_a", a_scan, pat[23-i]);
         chk("scan_out_c", c_scan, pat[23-i]);
         tick();
         chk("scan_out_pulse", a_pulse, 1'b0);
      end

      pat = 24'hFFFFF0;
      for (int i = 0; i < 24; i++) begin
         scan_in = pat[23-i];
         tick();
      end
      scan_en = 1'b0;
      scan_in = 1'b0;
      chk("wrap_c_fcw",    c_fcw, 24'h000020);
      chk("wrap_c_dco_hi", c_dco, 1'b1);
      tick();
      chk("wrap_c_dco_lo", c_dco, 1'b0);
      chk("wrap_c_pulse",  c_pulse, 1'b0);
      scan_en = 1'b1;
      pat = 24'h000010;
      for (int i = 0; i < 24; i++) begin
         chk("wrap_c_acc", c_scan, pat[23-i]);
         tick();
      end
      scan_en = 1'b0;

      repeat (300) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
